alu_accumulator: RTL and testbench

- Parametrised successor to the lab 8-bit ALU/accumulator pair.
- A WIDTH-bit operand from switches is combined with the low half of a 2*WIDTH-bit accumulator, and the result is written back to the accumulator.
- New relative to the previous generation: generic width, subtract mode, a sequential shift-add multiplier with a start/busy/done handshake, a synchronous clear, and status flags.
- Sits between the switch/key inputs and the 7-segment decoders that display acc.

---
 rtl/alu_accumulator.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_accumulator.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accumulator.sv
// alu_accumulator: WIDTH-bit ALU feeding a 2*WIDTH-bit accumulator.
// The operand B is always the low half of the accumulator. Single-cycle ops
// complete at the accepting edge. Op 111 runs a sequential shift-add multiply
// that takes WIDTH cycles and uses a start/busy/done handshake.
// Optional build macro ALU_ACCUMULATOR_SAT_EN: ops 000/001 saturate and op 010
// clamps to zero on borrow. The port list is the same in both builds.
module alu_accumulator #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               clear,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  output logic [2*WIDTH-1:0] acc,
  output logic               busy,
  output logic               done,
  output logic               carry,
  output logic               zero
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH:0]   TWO_W_L  = (WIDTH + 1)'(AW);
  localparam logic [WIDTH-1:0] W_L      = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [2:0]       OP_MUL   = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [AW-1:0]     acc_r, acc_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic              carry_r, carry_nxt_s;
  logic [AW-1:0]     mcand_r, mcand_nxt_s;
  logic [WIDTH-1:0]  mplier_r, mplier_nxt_s;
  logic [AW-1:0]     prod_r, prod_nxt_s;
  logic [CW-1:0]     cnt_r, cnt_nxt_s;
  logic [AW-1:0]     prod_step_s;
  logic              last_step_s;
  logic [AW:0]       alu_res_s;

  // Single-cycle result. MSB of the return value is the carry flag, and the
  // low AW bits are the new accumulator value.
  function automatic logic [AW:0] alu_result(
    input logic [2:0]       op_v,
    input logic [WIDTH-1:0] a_v,
    input logic [WIDTH-1:0] b_v
  );
    logic [WIDTH:0] sum_v;
    logic [AW-1:0]  res_v;
    logic [AW-1:0]  b_ext_v;
    logic           cy_v;
    sum_v   = {(WIDTH + 1){1'b0}};
    res_v   = {AW{1'b0}};
    cy_v    = 1'b0;
    b_ext_v = {{WIDTH{1'b0}}, b_v};
    case (op_v)
      3'b000, 3'b001: begin
        if (op_v == 3'b000) begin
          sum_v = {1'b0, a_v} + {{WIDTH{1'b0}}, 1'b1};
        end else begin
          sum_v = {1'b0, a_v} + {1'b0, b_v};
        end
        cy_v = sum_v[WIDTH];
`ifdef ALU_ACCUMULATOR_SAT_EN
        if (cy_v) begin
          res_v = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
        end else begin
          res_v = {{(WIDTH - 1){1'b0}}, sum_v};
        end
`else
        res_v = {{(WIDTH - 1){1'b0}}, sum_v};
`endif
      end
      3'b010: begin
        // Borrow lands in bit WIDTH of the (WIDTH+1)-bit difference.
        sum_v = {1'b0, a_v} - {1'b0, b_v};
        cy_v  = sum_v[WIDTH];
`ifdef ALU_ACCUMULATOR_SAT_EN
        if (cy_v) begin
          res_v = {AW{1'b0}};
        end else begin
          res_v = {{(WIDTH - 1){1'b0}}, sum_v};
        end
`else
        res_v = {{(WIDTH - 1){1'b0}}, sum_v};
`endif
      end
      3'b011: res_v = {a_v | b_v, a_v ^ b_v};
      3'b100: res_v = {{(AW - 1){1'b0}}, |{a_v, b_v}};
      3'b101: begin
        if ({1'b0, a_v} >= TWO_W_L) begin
          res_v = {AW{1'b0}};
        end else begin
          res_v = b_ext_v << a_v;
        end
      end
      3'b110: begin
        if (a_v >= W_L) begin
          res_v = {AW{1'b0}};
        end else begin
          res_v = b_ext_v >> a_v;
        end
      end
      default: res_v = {AW{1'b0}};
    endcase
    return {cy_v, res_v};
  endfunction

  // Multiplier step: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    prod_step_s = prod_r + (mplier_r[0] ? mcand_r : {AW{1'b0}});
    last_step_s = (cnt_r == LAST_CNT);
    alu_res_s   = alu_result(op, a, acc_r[WIDTH-1:0]);
  end

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: clear wins, IDLE launches multiplies, MUL runs WIDTH steps.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (op == OP_MUL)) begin
            state_nxt_s = ST_MUL;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (last_step_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_MUL;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values; start is ignored while a multiply runs.
  always_comb begin
    acc_nxt_s    = acc_r;
    carry_nxt_s  = carry_r;
    done_nxt_s   = 1'b0;
    mcand_nxt_s  = mcand_r;
    mplier_nxt_s = mplier_r;
    prod_nxt_s   = prod_r;
    cnt_nxt_s    = cnt_r;
    busy_nxt_s   = (state_nxt_s == ST_MUL);
    if (clear) begin
      acc_nxt_s   = {AW{1'b0}};
      carry_nxt_s = 1'b0;
      prod_nxt_s  = {AW{1'b0}};
      cnt_nxt_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (op == OP_MUL)) begin
            mcand_nxt_s  = {{WIDTH{1'b0}}, a};
            mplier_nxt_s = acc_r[WIDTH-1:0];
            prod_nxt_s   = {AW{1'b0}};
            cnt_nxt_s    = {CW{1'b0}};
          end else if (start) begin
            acc_nxt_s   = alu_res_s[AW-1:0];
            carry_nxt_s = alu_res_s[AW];
            done_nxt_s  = 1'b1;
          end else begin
            acc_nxt_s = acc_r;
          end
        end
        ST_MUL: begin
          prod_nxt_s   = prod_step_s;
          mcand_nxt_s  = {mcand_r[AW-2:0], 1'b0};
          mplier_nxt_s = {1'b0, mplier_r[WIDTH-1:1]};
          cnt_nxt_s    = cnt_r + CW'(1);
          if (last_step_s) begin
            acc_nxt_s   = prod_step_s;
            carry_nxt_s = 1'b0;
            done_nxt_s  = 1'b1;
            cnt_nxt_s   = {CW{1'b0}};
          end else begin
            done_nxt_s = 1'b0;
          end
        end
        default: begin
          acc_nxt_s = acc_r;
        end
      endcase
    end
  end

  // Accumulator, flags and multiplier working registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_r    <= {AW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      carry_r  <= 1'b0;
      mcand_r  <= {AW{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      prod_r   <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      acc_r    <= acc_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
      carry_r  <= carry_nxt_s;
      mcand_r  <= mcand_nxt_s;
      mplier_r <= mplier_nxt_s;
      prod_r   <= prod_nxt_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  assign acc   = acc_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign carry = carry_r;
  assign zero  = (acc_r == {AW{1'b0}});

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator (WIDTH=4). Expected results are pushed
// to a scoreboard queue when an op is launched and popped when done pulses.
module tb_alu_accumulator;

  localparam int W = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           start;
  logic           clear;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [2*W-1:0] acc;
  logic           busy;
  logic           done;
  logic           carry;
  logic           zero;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] acc;
    logic       carry;
  } exp_t;

  exp_t sb_q[$];

`ifdef ALU_ACCUMULATOR_SAT_EN
  localparam logic [7:0] EXP_ADD = 8'h0F;
  localparam logic [7:0] EXP_SUB = 8'h00;
  localparam logic [7:0] EXP_INC = 8'h0F;
`else
  localparam logic [7:0] EXP_ADD = 8'h15;
  localparam logic [7:0] EXP_SUB = 8'h1E;
  localparam logic [7:0] EXP_INC = 8'h10;
`endif

  alu_accumulator #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .clear   (clear),
    .op      (op),
    .a       (a),
    .acc     (acc),
    .busy    (busy),
    .done    (done),
    .carry   (carry),
    .zero    (zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_acc"}, 32'(acc), 32'(e.acc));
      check({tag, "_carry"}, 32'(carry), 32'(e.carry));
    end else begin
      e.acc = 8'h00;
    end
  endtask

  task automatic wait_done(input string tag, input int max_cyc, output int cyc);
    cyc = 0;
    while (!done && cyc < max_cyc) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // One single-cycle op: launch, expect done one cycle later, then a clean pulse.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [7:0] eacc, input logic ec);
    int cyc;
    op    = o;
    a     = av;
    start = 1'b1;
    sb_q.push_back('{acc: eacc, carry: ec});
    @(negedge clock);
    start = 1'b0;
    wait_done(tag, 8, cyc);
    check({tag, "_lat"}, 32'(cyc), 32'd0);
    pop_check(tag);
    @(negedge clock);
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    int dcnt;
    int seen;

    reset_n = 1'b0;
    start   = 1'b0;
    clear   = 1'b0;
    op      = 3'b000;
    a       = 4'h0;
    repeat (2) @(negedge clock);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_hold", 32'(acc), 32'd0);

    run_op("inc5", 3'b000, 4'h5, 8'h06, 1'b0);
    check("inc5_zero", 32'(zero), 32'd0);
    run_op("add_f", 3'b001, 4'hF, EXP_ADD, 1'b1);

    pulse_clear();
    check("clr_acc", 32'(acc), 32'd0);
    check("clr_carry", 32'(carry), 32'd0);
    check("clr_zero", 32'(zero), 32'd1);

    // Multiply 0xF * 0x5 with start pulses while busy.
    run_op("inc4", 3'b000, 4'h4, 8'h05, 1'b0);
    op    = 3'b111;
    a     = 4'hF;
    start = 1'b1;
    sb_q.push_back('{acc: 8'h4B, carry: 1'b0});
    bcnt = 0;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (done) begin
        start = 1'b0;
        seen  = 1;
        break;
      end
      if (busy) begin
        bcnt++;
        check("mul_acc_hold", 32'(acc), 32'h05);
      end
      op    = 3'b000;
      a     = 4'h0;
      start = ~start;
    end
    check("mul_done_seen", 32'(seen), 32'd1);
    check("mul_busy_cycles", 32'(bcnt), 32'd4);
    check("mul_busy_end", 32'(busy), 32'd0);
    pop_check("mul");
    @(negedge clock);
    check("mul_pulse", 32'(done), 32'd0);
    check("mul_no_late_start", 32'(acc), 32'h4B);

    // Clear two cycles into a multiply.
    op    = 3'b111;
    a     = 4'h3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    @(negedge clock);
    pulse_clear();
    check("abort_acc", 32'(acc), 32'd0);
    check("abort_busy_low", 32'(busy), 32'd0);
    check("abort_zero", 32'(zero), 32'd1);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dcnt++;
      @(negedge clock);
    end
    check("abort_no_done", 32'(dcnt), 32'd0);

    // Asynchronous reset in the middle of a multiply.
    run_op("inc2a", 3'b000, 4'h2, 8'h03, 1'b0);
    op    = 3'b111;
    a     = 4'h3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("arst_busy_pre", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_acc", 32'(acc), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_zero", 32'(zero), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_op("inc2b", 3'b000, 4'h2, 8'h03, 1'b0);
    run_op("sub_borrow", 3'b010, 4'h1, EXP_SUB, 1'b1);
    pulse_clear();
    run_op("inc2c", 3'b000, 4'h2, 8'h03, 1'b0);
    run_op("shl9", 3'b101, 4'h9, 8'h00, 1'b0);
    check("shl9_zero", 32'(zero), 32'd1);
    run_op("inc2d", 3'b000, 4'h2, 8'h03, 1'b0);
    run_op("shl2", 3'b101, 4'h2, 8'h0C, 1'b0);
    run_op("inc5b", 3'b000, 4'h5, 8'h06, 1'b0);
    run_op("or_xor", 3'b011, 4'hA, 8'hEC, 1'b0);
    run_op("shr2", 3'b110, 4'h2, 8'h03, 1'b0);
    run_op("orr", 3'b100, 4'h0, 8'h01, 1'b0);
    run_op("shr4", 3'b110, 4'h4, 8'h00, 1'b0);
    run_op("orr0", 3'b100, 4'h0, 8'h00, 1'b0);
    check("orr0_zero", 32'(zero), 32'd1);

    // Back-to-back single-cycle ops on consecutive cycles.
    op    = 3'b000;
    a     = 4'h7;
    start = 1'b1;
    sb_q.push_back('{acc: 8'h08, carry: 1'b0});
    @(negedge clock);
    check("b2b1_done", 32'(done), 32'd1);
    pop_check("b2b1");
    op = 3'b001;
    a  = 4'h1;
    sb_q.push_back('{acc: 8'h09, carry: 1'b0});
    @(negedge clock);
    start = 1'b0;
    check("b2b2_done", 32'(done), 32'd1);
    pop_check("b2b2");

    run_op("sub_nb", 3'b010, 4'hC, 8'h03, 1'b0);
    run_op("inc_cy", 3'b000, 4'hF, EXP_INC, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
